phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit processor core.
- Steps the datapath through five phases (fetch, decode, execute, memory, write-back) and issues the register write strobes: IR, PC, register file and memory.
- Sits between the instruction register and the datapath. It consumes the opcode and the write-enable decode produced by the data-select controller, and handshakes with instruction/data memory.

Parameters:
- ACK_TIMEOUT, 16, max cycles to wait for mem_ack in a memory phase before error; 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; begin execution from IDLE
- stop  in  1  level; sampled at end of WB, returns to IDLE
- op  in  16  current instruction word from IR (valid from ID onward)
- write_order  in  1  register-file write enable decoded from op
- mem_ack  in  1  memory completion, one cycle, valid while mem_re/mem_we high
- phase  out  5  one-hot phase: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB; 0 otherwise
- mem_re  out  1  memory read request
- mem_we  out  1  memory write request
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- reg_we  out  1  register-file write strobe
- running  out  1  high in any of IF..WB
- halted  out  1  HLT executed; sticky until rst
- err  out  1  memory timeout; sticky until rst
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, IF, ID, EX, MEM, WB, HALT, ERR. State is registered. Outputs are decoded from state, plus mem_ack where noted.
- Reset (rst=1 at clock edge, overrides all):
  - state goes to IDLE; wait counter cleared; instr_cnt cleared; halted=0; err=0.
  - All strobes are 0 and phase=0 in the following cycle.
- IDLE: start=1 moves to IF next cycle; otherwise stay.
- IF:
  - mem_re=1.
  - ir_we = mem_ack (same cycle).
  - mem_ack=1 moves to ID and clears the wait counter. Otherwise the wait counter increments.
- ID: one cycle.
  - HLT (op[15:14]=11, op[7:4]=1111) moves to HALT.
  - Otherwise moves to EX.
- EX: one cycle.
  - op[15:14]=00 (load) or 01 (store) moves to MEM.
  - All other opcodes move directly to WB; MEM is skipped.
- MEM:
  - Load: mem_re=1. Store: mem_we=1.
  - mem_ack=1 moves to WB; otherwise wait. Same counter rules as IF.
- WB: one cycle.
  - pc_we=1; reg_we=write_order.
  - instr_cnt increments, wrapping at 2^CNT_W to 0.
  - Next state: stop=1 goes to IDLE; else IF.
- Timeout: when ACK_TIMEOUT>0 and the wait counter reaches ACK_TIMEOUT-1 with mem_ack=0 in IF or MEM, go to ERR next cycle.
  - mem_ack arriving in that same cycle wins; no error.
- HALT: halted=1, all strobes 0, phase=0. start is ignored; only rst exits.
- ERR: err=1, all strobes 0. Only rst exits.
- At most one of mem_re/mem_we is high in any cycle.
- mem_ack outside IF/MEM is ignored.
- start held high continuously gives back-to-back instructions with no IDLE cycle.
- stop asserted mid-instruction takes effect only at WB. The instruction always completes.
- Minimum latency: 4 cycles per non-memory instruction, 5 per load/store (with mem_ack in the first cycle of each wait).

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined, two extra inputs:
  - step_mode (level)
  - step (one-cycle pulse)
- Behaviour with the macro:
  - In IDLE, step=1 also moves to IF.
  - In WB, step_mode=1 forces the next state to IDLE, so exactly one instruction runs per step pulse.
  - start retains its normal meaning.
- When undefined, the ports are absent and behaviour equals step_mode=0.

Test Plan:
- rst, then start=1; op=0xC000 (ADD), write_order=1, mem_ack on first IF cycle -> phase sequence 01,02,04,10 (hex); reg_we=1 and pc_we=1 in WB; instr_cnt=1 after 4 cycles.
- Load op=0x0000, mem_ack delayed 3 cycles in MEM -> mem_re held 4 cycles in MEM; WB follows the ack cycle; 1 retired instruction counted in 8 cycles total.
- Store op=0x4000 -> mem_we=1 only in MEM; mem_re=0 throughout MEM.
- Fetch HLT op=0xC0F0 -> HALT after ID; halted=1; pc_we never asserted; start pulses ignored until rst.
- ACK_TIMEOUT=4, mem_ack held 0 in IF -> err=1 on the 5th cycle after entering IF; strobes 0; rst clears err.
- instr_cnt preset by running 0xFFFF instructions with CNT_W=16 -> the next WB wraps it to 0x0000. stop=1 raised during EX -> that instruction completes, then IDLE.

Source files
------------

// File: rtl/phase_sequencer.sv
// Five-phase control sequencer (IF/ID/EX/MEM/WB) issuing IR, PC, register-file and memory strobes.
// Optional SINGLE_STEP_EN adds step_mode/step inputs for one-instruction-per-pulse execution.
module phase_sequencer #(
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [15:0]      op,
   input  logic             write_order,
   input  logic             mem_ack,
`ifdef SINGLE_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   output logic [4:0]       phase,
   output logic             mem_re,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             reg_we,
   output logic             running,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
   } state_t;

   localparam int                WAIT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam bit                TIMEOUT_EN = (ACK_TIMEOUT > 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
   logic [4:0]         phase_q, phase_d;
   logic               mem_re_q, mem_re_d;
   logic               mem_we_q, mem_we_d;
   logic               pc_we_q, pc_we_d;
   logic               running_q, running_d;
   logic               halted_q, halted_d;
   logic               err_q, err_d;
   logic               step_go;
   logic               step_hold;
   logic               is_hlt;
   logic               unused_op;

`ifdef SINGLE_STEP_EN
   assign step_go   = step;
   assign step_hold = step_mode;
`else
   assign step_go   = 1'b0;
   assign step_hold = 1'b0;
`endif

   assign is_hlt    = (op[15:14] == 2'b11) && (op[7:4] == 4'hF);
   assign unused_op = ^{op[13:8], op[3:0]};

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      instr_cnt_d = instr_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (start || step_go) state_d = S_IF;
         end
         S_IF, S_MEM: begin
            // An ack in the final allowed cycle still counts as success.
            if (mem_ack) begin
               state_d = (state_q == S_IF) ? S_ID : S_WB;
               wait_d  = '0;
            end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_ID:   state_d = is_hlt ? S_HALT : S_EX;
         S_EX:   state_d = op[15] ? S_WB : S_MEM;
         S_WB: begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
            state_d     = (stop || step_hold) ? S_IDLE : S_IF;
         end
         S_HALT: state_d = S_HALT;
         S_ERR:  state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with state_q.
   always_comb begin
      phase_d = 5'b00000;
      unique case (state_d)
         S_IF:    phase_d = 5'b00001;
         S_ID:    phase_d = 5'b00010;
         S_EX:    phase_d = 5'b00100;
         S_MEM:   phase_d = 5'b01000;
         S_WB:    phase_d = 5'b10000;
         default: phase_d = 5'b00000;
      endcase
      mem_re_d  = (state_d == S_IF) || ((state_d == S_MEM) && !op[14]);
      mem_we_d  = (state_d == S_MEM) && op[14];
      pc_we_d   = (state_d == S_WB);
      running_d = (phase_d != 5'b00000);
      halted_d  = (state_d == S_HALT);
      err_d     = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         instr_cnt_q <= '0;
         phase_q     <= 5'b00000;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         pc_we_q     <= 1'b0;
         running_q   <= 1'b0;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         instr_cnt_q <= instr_cnt_d;
         phase_q     <= phase_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         pc_we_q     <= pc_we_d;
         running_q   <= running_d;
         halted_q    <= halted_d;
         err_q       <= err_d;
      end
   end

   assign phase     = phase_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign ir_we     = phase_q[0] & mem_ack;
   assign pc_we     = pc_we_q;
   assign reg_we    = pc_we_q & write_order;
   assign running   = running_q;
   assign halted    = halted_q;
   assign err       = err_q;
   assign instr_cnt = instr_cnt_q;

endmodule
